// File: rtl/ctrl_de.sv
// ctrl_de: Decode->Execute control register with stall/flush and multi-cycle FPU hold
module ctrl_de #(
    parameter int FP_LAT = 4,
    parameter int ALUC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ResultSrcD,
    input  logic              RegWriteD,
    input  logic              FRegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic              FpuMultiD,
    output logic              ResultSrcE,
    output logic              RegWriteE,
    output logic              FRegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              FpuBusyE,
    output logic              FpuDoneE
);
    typedef enum logic [1:0] {CLEAR, RUN, FPU_WAIT} state_t;
    state_t state;
    logic [3:0] cnt;
    logic regWrite, fRegWrite, memWrite;
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            cnt <= '0;
            {ResultSrcE, regWrite, fRegWrite, memWrite, JumpE, BranchE, ALUSrcE} <= '0;
            ALUControlE <= '0;
        end else if (state == CLEAR) begin
            state <= RUN;
        end else if (state == FPU_WAIT && cnt != 0) begin
            cnt <= cnt - 4'd1;
        end else begin
            // last FPU_WAIT edge is handled exactly like a RUN edge
            state <= RUN;
            if (FlushE) begin
                {ResultSrcE, regWrite, fRegWrite, memWrite, JumpE, BranchE, ALUSrcE} <= '0;
                ALUControlE <= '0;
            end else if (!StallE) begin
                {ResultSrcE, regWrite, fRegWrite, memWrite, JumpE, BranchE, ALUSrcE} <=
                    {ResultSrcD, RegWriteD, FRegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD};
                ALUControlE <= ALUControlD;
                if (FpuMultiD && FP_LAT > 1) begin
                    state <= FPU_WAIT;
                    cnt <= 4'(FP_LAT - 1);
                end
            end
        end
    end
    assign FpuBusyE = state == FPU_WAIT && cnt != 0;
    assign FpuDoneE = state == FPU_WAIT && cnt == 0;
    // write enables are bubbled to M until the op's final cycle
    assign RegWriteE = regWrite & ~FpuBusyE;
    assign FRegWriteE = fRegWrite & ~FpuBusyE;
    assign MemWriteE = memWrite & ~FpuBusyE;
endmodule

// File: tb/tb_ctrl_de.sv
// tb_ctrl_de: table-driven check of ctrl_de stall/flush/clear-edge/FPU hold behaviour
module tb_ctrl_de;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic StallE, FlushE, ResultSrcD, RegWriteD, FRegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, FpuMultiD;
    logic [3:0] ALUControlD;
    logic ResultSrcE, RegWriteE, FRegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, FpuBusyE, FpuDoneE;
    logic [3:0] ALUControlE;
    logic [12:0] o;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [13:0] in;
        logic [12:0] exp;
        string nm;
    } vec_t;
    vec_t vq[$];

    ctrl_de #(.FP_LAT(4), .ALUC_W(4)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .ResultSrcD(ResultSrcD), .RegWriteD(RegWriteD), .FRegWriteD(FRegWriteD),
        .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .FpuMultiD(FpuMultiD),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .FRegWriteE(FRegWriteE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .FpuBusyE(FpuBusyE), .FpuDoneE(FpuDoneE)
    );

    always #5 clk = ~clk;
    assign o = {ResultSrcE, RegWriteE, FRegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE, FpuBusyE, FpuDoneE};

    // {stall, flush, rs, rw, frw, mw, j, b, as, alu, fm}
    function automatic logic [13:0] vi(input logic s, f, rs, rw, frw, mw, j, b, as, input logic [3:0] alu, input logic fm);
        return {s, f, rs, rw, frw, mw, j, b, as, alu, fm};
    endfunction
    // {rs, rw, frw, mw, j, b, as, alu, busy, done}
    function automatic logic [12:0] vo(input logic rs, rw, frw, mw, j, b, as, input logic [3:0] alu, input logic bz, dn);
        return {rs, rw, frw, mw, j, b, as, alu, bz, dn};
    endfunction

    task automatic drive(input logic [13:0] v);
        {StallE, FlushE, ResultSrcD, RegWriteD, FRegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD, FpuMultiD} = v;
    endtask

    task automatic check(input string nm, input logic [12:0] exp);
        total++;
        if (o !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, o, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vq.push_back('{vi(0,0,0,1,0,0,0,0,0,4'h0,0), vo(0,0,0,0,0,0,0,4'h0,0,0), "clear_edge"});
        vq.push_back('{vi(0,0,0,1,0,0,0,0,0,4'h0,0), vo(0,1,0,0,0,0,0,4'h0,0,0), "first_load"});
        vq.push_back('{vi(0,0,1,0,0,1,0,0,1,4'h6,0), vo(1,0,0,1,0,0,1,4'h6,0,0), "load_0110"});
        for (int i = 0; i < 3; i++)
            vq.push_back('{vi(1,0,0,0,0,0,0,0,0,4'h0,0), vo(1,0,0,1,0,0,1,4'h6,0,0), "stall_hold"});
        vq.push_back('{vi(0,0,0,1,0,0,1,1,0,4'h2,0), vo(0,1,0,0,1,1,0,4'h2,0,0), "load_rw"});
        vq.push_back('{vi(1,1,1,1,1,1,1,1,1,4'hf,1), vo(0,0,0,0,0,0,0,4'h0,0,0), "flush_wins"});
        vq.push_back('{vi(0,0,0,0,1,0,0,0,0,4'h3,1), vo(0,0,0,0,0,0,0,4'h3,1,0), "fpu_busy1"});
        vq.push_back('{vi(0,1,0,1,0,0,0,0,0,4'h1,0), vo(0,0,0,0,0,0,0,4'h3,1,0), "fpu_busy2_flush"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,0,0,0,0,0,4'h3,1,0), "fpu_busy3"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,1,0,0,0,0,4'h3,0,1), "fpu_done"});
        vq.push_back('{vi(0,0,0,1,0,0,0,0,0,4'h5,0), vo(0,1,0,0,0,0,0,4'h5,0,0), "after_done"});
        vq.push_back('{vi(0,0,0,0,1,0,0,0,0,4'h8,1), vo(0,0,0,0,0,0,0,4'h8,1,0), "b2b_a_busy1"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,0,0,0,0,0,4'h8,1,0), "b2b_a_busy2"});
        vq.push_back('{vi(1,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,0,0,0,0,0,4'h8,1,0), "b2b_a_busy3"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,1,0,0,0,0,4'h8,0,1), "b2b_a_done"});
        vq.push_back('{vi(0,0,0,1,1,0,0,0,0,4'h9,1), vo(0,0,0,0,0,0,0,4'h9,1,0), "b2b_b_busy1"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,0,0,0,0,0,4'h9,1,0), "b2b_b_busy2"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,0,0,0,0,0,4'h9,1,0), "b2b_b_busy3"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,1,1,0,0,0,0,4'h9,0,1), "b2b_b_done"});
        vq.push_back('{vi(0,0,0,0,0,0,0,0,0,4'h0,0), vo(0,0,0,0,0,0,0,4'h0,0,0), "load_zero"});

        drive(vi(0,0,1,1,1,1,1,1,1,4'hf,1));
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", vo(0,0,0,0,0,0,0,4'h0,0,0));
        reset = 1'b1;
        foreach (vq[k]) begin
            drive(vq[k].in);
            cyc();
            check(vq[k].nm, vq[k].exp);
        end

        drive(vi(0,0,0,1,1,0,0,0,0,4'h7,1));
        cyc();
        check("rst_busy1", vo(0,0,0,0,0,0,0,4'h7,1,0));
        drive(vi(0,0,0,1,0,0,0,0,0,4'h0,0));
        cyc();
        check("rst_busy2", vo(0,0,0,0,0,0,0,4'h7,1,0));
        reset = 1'b0;
        #1;
        check("rst_async", vo(0,0,0,0,0,0,0,4'h0,0,0));
        cyc();
        check("rst_held", vo(0,0,0,0,0,0,0,4'h0,0,0));
        reset = 1'b1;
        cyc();
        check("rst_clear_edge", vo(0,0,0,0,0,0,0,4'h0,0,0));
        cyc();
        check("rst_first_load", vo(0,1,0,0,0,0,0,4'h0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ctrl_de.md
# ctrl_de

Decode→Execute control pipeline register for the e5rv32 pipeline. Captures the decoded control word on the falling clock edge, applies hazard-unit stall/flush, discards the first active edge after reset, and sequences multi-cycle FPU operations by holding the word in Execute for FP_LAT cycles while presenting a bubble to the E→M control register.

## Interface
- FP_LAT, default 4: cycles a multi-cycle FPU op occupies Execute; legal 1..15; 1 disables the hold.
- ALUC_W, default 4: width of ALU control field.
- clk  in  1  clock; all state updates on negedge.
- reset  in  1  asynchronous, active-low reset.
- StallE  in  1  hold Execute register (from hazard unit).
- FlushE  in  1  load a bubble (all-zero control word).
- ResultSrcD, RegWriteD, FRegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decoded control.
- ALUControlD  in  ALUC_W  ALU operation.
- FpuMultiD  in  1  decoded op is a multi-cycle FPU op.
- ResultSrcE, RegWriteE, FRegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  Execute control.
- ALUControlE  out  ALUC_W  Execute ALU operation.
- FpuBusyE  out  1  multi-cycle op occupying Execute, not in last cycle; hazard unit stalls F/D on it.
- FpuDoneE  out  1  last Execute cycle of a multi-cycle op.

## Operation
- States: CLEAR, RUN, FPU_WAIT. 4-bit down-counter cnt.
- reset low (async): all registered control bits 0, cnt 0, state CLEAR. All outputs 0.
- CLEAR: next negedge → RUN; register stays 0; inputs ignored.
- RUN, each negedge, priority order:
  - FlushE=1: register ← 0 (overrides StallE); state stays RUN.
  - StallE=1: register holds.
  - else register ← D inputs; if FpuMultiD=1 and FP_LAT>1: state → FPU_WAIT, cnt ← FP_LAT−1.
- FPU_WAIT, each negedge:
  - cnt≠0: register holds, cnt ← cnt−1; StallE and FlushE ignored (op committed).
  - cnt=0: state → RUN and the edge is processed exactly as a RUN edge (flush/stall/load, may re-enter FPU_WAIT).
- Outputs:
  - FpuBusyE = (state=FPU_WAIT) and cnt≠0.
  - FpuDoneE = (state=FPU_WAIT) and cnt=0.
  - RegWriteE, FRegWriteE, MemWriteE = registered value AND NOT FpuBusyE (bubble to M during hold; single write on final cycle).
  - All other E outputs = registered value directly.
- FpuMultiD stored is not an output; FP_LAT=1 treats multi-cycle ops as single-cycle (FpuBusyE, FpuDoneE never assert).

## Timing
- Latency D→E: one negedge (registered on falling edge, visible for the following clock period).
- First negedge after reset release never loads; second negedge is first load.
- Multi-cycle op: present in E for exactly FP_LAT cycles; FpuBusyE high FP_LAT−1 cycles, FpuDoneE high 1 cycle; write-enables visible only in the FpuDoneE cycle.
- FlushE and StallE both high in RUN: flush wins.
- Reset mid-FPU_WAIT: immediate abort, all outputs 0, next negedge is CLEAR.
- No combinational path from any D input to any output.

## Test plan
- Reset release, RegWriteD=1 held: RegWriteE=0 after first negedge, 1 after second.
- RUN, load ALUControlD=4'b0110, MemWriteD=1, then StallE=1 three edges with D changed to 0: E holds 0110/1 all three.
- StallE=1 and FlushE=1 same edge, RegWriteE was 1: all E outputs 0 next cycle.
- FP_LAT=4, FpuMultiD=1, FRegWriteD=1: FpuBusyE=1 three cycles with FRegWriteE=0, then FpuDoneE=1 with FRegWriteE=1 one cycle; FlushE pulsed during busy has no effect; next word loads on the edge ending the done cycle.
- Back-to-back multi-cycle ops (StallE low at done edge): second op enters directly, FpuBusyE low only during done cycle.
- reset pulsed in 2nd busy cycle: outputs 0 immediately; after release one ignored edge, then normal load.
